digital_demod: RTL

DIGITAL_DEMOD -- requirements
Module: DigitalDemod

---
 rtl/digital_demod.sv | 122 ++++++++++++
 1 files changed

// File: rtl/digital_demod.sv
// Synchronous I/Q demodulator: accumulates 4-samples-per-period ADC data into I/Q sums
// after a settling discard, and hands back the truncated result on a level-held handshake.
module digital_demod #(
    parameter int NPER  = 16,
    parameter int NDISC = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        DemodEn,
    input  logic [13:0] AdcData,
    input  logic        AdcValid,
    input  logic        AdcOvr,
    output logic        DemodReady,
    output logic [31:0] DemodResult,
    output logic        DemodBusy,
    output logic        OvrFlag
);

    localparam int NSAMP  = 4 * NPER;
    localparam int SAMP_W = $clog2(NSAMP);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(NSAMP - 1);
    localparam logic [7:0]        DISC_LAST = (NDISC == 0) ? 8'd0 : 8'(NDISC - 1);

    typedef enum logic [1:0] {IDLE, DISCARD, ACC, DONE} state_t;

    state_t             state_q;
    logic [7:0]         disc_cnt_q;
    logic [SAMP_W-1:0]  samp_cnt_q;
    logic signed [23:0] iacc_q, qacc_q;
    logic signed [23:0] iacc_d, qacc_d;
    logic signed [23:0] sample;
    logic [1:0]         phase;
    logic               ready_q;
    logic               ovr_q;
    logic [31:0]        result_q;

    assign sample = {{10{AdcData[13]}}, AdcData};
    // Phase index is the low two bits of the ACC sample counter, so it wraps 3->0 for free.
    assign phase  = samp_cnt_q[1:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        iacc_d = iacc_q;
        qacc_d = qacc_q;
        case (phase)
            2'd0: iacc_d = iacc_q + sample;
            2'd1: qacc_d = qacc_q + sample;
            2'd2: iacc_d = iacc_q - sample;
            2'd3: qacc_d = qacc_q - sample;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            disc_cnt_q <= '0;
            samp_cnt_q <= '0;
            iacc_q     <= '0;
            qacc_q     <= '0;
            ready_q    <= 1'b0;
            ovr_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (DemodEn) begin
                        disc_cnt_q <= '0;
                        samp_cnt_q <= '0;
                        iacc_q     <= '0;
                        qacc_q     <= '0;
                        ovr_q      <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= (NDISC == 0) ? ACC : DISCARD;
                    end
                end
                DISCARD: begin
                    if (!DemodEn) begin
                        state_q <= IDLE;
                    end else if (AdcValid) begin
                        if (disc_cnt_q == DISC_LAST) begin
                            state_q <= ACC;
                        end else begin
                            disc_cnt_q <= disc_cnt_q + 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (!DemodEn) begin
                        state_q <= IDLE;
                    end else if (AdcValid) begin
                        iacc_q     <= iacc_d;
                        qacc_q     <= qacc_d;
                        samp_cnt_q <= samp_cnt_q + 1'b1;
                        if (AdcOvr) begin
                            ovr_q <= 1'b1;
                        end
                        // Result captured from the sums including this final sample.
                        if (samp_cnt_q == SAMP_LAST) begin
                            result_q <= {iacc_d[23:8], qacc_d[23:8]};
                            ready_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!DemodEn) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DemodReady  = ready_q;
    assign DemodResult = result_q;
    assign DemodBusy   = (state_q == DISCARD) || (state_q == ACC);
    assign OvrFlag     = ovr_q;

endmodule
